// File: rtl/varredura_pkg.sv
// rtl/varredura_pkg.sv - shared constants, nibble type and one-hot helper for the digit scanner
package varredura_pkg;

    localparam int N_DIGITOS_PADRAO   = 4;
    localparam int DIV_REFRESH_PADRAO = 50000;

    typedef logic [3:0] nibble_t;

    // Digit select with bit idx set; callers size-cast to their digit count.
    function automatic logic [31:0] onehot(input int unsigned idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/divisor_refresh.sv
// rtl/divisor_refresh.sv - prescaler producing one tick every DIV enabled clk cycles
module divisor_refresh #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Count while enabled, wrap on tick, hold when disabled.
    always_comb begin
        tick    = en && (count_q == CW'(DIV - 1));
        count_d = count_q;
        if (tick) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - multiplexed hex scan controller; VARREDURA_SUPRIME_ZEROS_EN enables leading-zero blanking
module varredura_display
    import varredura_pkg::*;
#(
    parameter  int N_DIGITOS   = N_DIGITOS_PADRAO,
    parameter  int DIV_REFRESH = DIV_REFRESH_PADRAO,
    localparam int IW          = $clog2(N_DIGITOS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*N_DIGITOS-1:0] valor,
    input  logic                   carga,
    input  logic                   habilita,
    output logic [3:0]             digito,
    output logic [N_DIGITOS-1:0]   anodo,
    output logic [IW-1:0]          indice,
    output logic                   quadro,
    output logic                   pendente
);

    logic                   tick;
    logic                   inicio_quadro;
    logic                   apagar;

    logic [IW-1:0]          indice_q,   indice_d;
    logic [4*N_DIGITOS-1:0] shadow_q,   shadow_d;
    logic [4*N_DIGITOS-1:0] buffer_q,   buffer_d;
    logic                   pendente_q, pendente_d;
    nibble_t                digito_q,   digito_d;
    logic [N_DIGITOS-1:0]   anodo_q,    anodo_d;
    logic                   quadro_q,   quadro_d;

    divisor_refresh #(
        .DIV (DIV_REFRESH)
    ) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (habilita),
        .tick  (tick)
    );

    // Slot advance, frame-boundary commit of the shadow value, and next output values.
    always_comb begin
        indice_d      = indice_q;
        shadow_d      = shadow_q;
        buffer_d      = buffer_q;
        pendente_d    = pendente_q;
        digito_d      = digito_q;
        anodo_d       = anodo_q;
        quadro_d      = 1'b0;
        apagar        = 1'b0;
        inicio_quadro = 1'b0;

        if (tick) begin
            indice_d = (indice_q == IW'(N_DIGITOS - 1)) ? '0 : indice_q + IW'(1);
        end
        inicio_quadro = tick && (indice_d == '0);

        // A load on the frame-start cycle bypasses the buffer so slot 0 already shows it.
        if (inicio_quadro) begin
            if (pendente_q || carga) begin
                shadow_d = carga ? valor : buffer_q;
            end
            pendente_d = 1'b0;
        end else if (carga) begin
            buffer_d   = valor;
            pendente_d = 1'b1;
        end

`ifdef VARREDURA_SUPRIME_ZEROS_EN
        // Blank slot k>0 when it and every more-significant nibble are zero.
        apagar = (indice_d != '0) && ((shadow_d >> (4 * indice_d)) == '0);
`endif

        if (tick) begin
            digito_d = shadow_d[4*indice_d +: 4];
            anodo_d  = apagar ? '0 : N_DIGITOS'(onehot(32'(indice_d)));
            quadro_d = inicio_quadro;
        end else if (!habilita) begin
            anodo_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            indice_q   <= IW'(N_DIGITOS - 1);
            shadow_q   <= '0;
            buffer_q   <= '0;
            pendente_q <= 1'b0;
            digito_q   <= '0;
            anodo_q    <= '0;
            quadro_q   <= 1'b0;
        end else begin
            indice_q   <= indice_d;
            shadow_q   <= shadow_d;
            buffer_q   <= buffer_d;
            pendente_q <= pendente_d;
            digito_q   <= digito_d;
            anodo_q    <= anodo_d;
            quadro_q   <= quadro_d;
        end
    end

    assign digito   = digito_q;
    assign anodo    = anodo_q;
    assign indice   = indice_q;
    assign quadro   = quadro_q;
    assign pendente = pendente_q;

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - directed self-checking bench for varredura_display (4 digits, 4 cycles per slot)
module tb_varredura_display;

    localparam int N  = 4;
    localparam int DV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   valor;
    logic          carga;
    logic          habilita;
    logic [3:0]    digito;
    logic [3:0]    anodo;
    logic [1:0]    indice;
    logic          quadro;
    logic          pendente;

    int n_cmp = 0;
    int n_err = 0;

    varredura_display #(
        .N_DIGITOS   (N),
        .DIV_REFRESH (DV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valor    (valor),
        .carga    (carga),
        .habilita (habilita),
        .digito   (digito),
        .anodo    (anodo),
        .indice   (indice),
        .quadro   (quadro),
        .pendente (pendente)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] a, input logic [3:0] d,
                            input logic [1:0] i, input logic q);
        chk({tag, ".anodo"},  16'(anodo),  16'(a));
        chk({tag, ".digito"}, 16'(digito), 16'(d));
        chk({tag, ".indice"}, 16'(indice), 16'(i));
        chk({tag, ".quadro"}, 16'(quadro), 16'(q));
    endtask

    initial begin
        rst_n = 1'b0; valor = '0; carga = 1'b0; habilita = 1'b0;

        // Reset held for two edges, then release with scanning enabled.
        cyc(2);
        chk_slot("rst", 4'b0000, 4'h0, 2'd3, 1'b0);
        chk("rst.pendente", 16'(pendente), 16'd0);
        rst_n = 1'b1; habilita = 1'b1;

        // Load 1234 in cycle 1; first tick lands at cycle 4.
        cyc(1);
        chk_slot("c1", 4'b0000, 4'h0, 2'd3, 1'b0);
        carga = 1'b1; valor = 16'h1234;
        cyc(1);
        carga = 1'b0;
        chk("c2.pendente", 16'(pendente), 16'd1);
        chk("c2.anodo", 16'(anodo), 16'd0);
        cyc(1);
        chk("c3.anodo", 16'(anodo), 16'd0);
        cyc(1);
        chk_slot("f1s0", 4'b0001, 4'h4, 2'd0, 1'b1);
        chk("f1s0.pendente", 16'(pendente), 16'd0);
        cyc(1);
        chk_slot("f1s0+1", 4'b0001, 4'h4, 2'd0, 1'b0);
        cyc(3);
        chk_slot("f1s1", 4'b0010, 4'h3, 2'd1, 1'b0);
        cyc(4);
        chk_slot("f1s2", 4'b0100, 4'h2, 2'd2, 1'b0);
        cyc(4);
        chk_slot("f1s3", 4'b1000, 4'h1, 2'd3, 1'b0);
        cyc(4);
        chk_slot("f2s0", 4'b0001, 4'h4, 2'd0, 1'b1);
        cyc(4);
        chk_slot("f2s1", 4'b0010, 4'h3, 2'd1, 1'b0);

        // Mid-frame load: rest of this frame keeps the old value.
        carga = 1'b1; valor = 16'hABCD;
        cyc(1);
        carga = 1'b0;
        chk("mid.pendente", 16'(pendente), 16'd1);
        cyc(3);
        chk_slot("f2s2", 4'b0100, 4'h2, 2'd2, 1'b0);
        chk("f2s2.pendente", 16'(pendente), 16'd1);
        cyc(4);
        chk_slot("f2s3", 4'b1000, 4'h1, 2'd3, 1'b0);
        cyc(4);
        chk_slot("f3s0", 4'b0001, 4'hD, 2'd0, 1'b1);
        chk("f3s0.pendente", 16'(pendente), 16'd0);
        cyc(4);
        chk_slot("f3s1", 4'b0010, 4'hC, 2'd1, 1'b0);
        cyc(4);
        chk_slot("f3s2", 4'b0100, 4'hB, 2'd2, 1'b0);
        cyc(4);
        chk_slot("f3s3", 4'b1000, 4'hA, 2'd3, 1'b0);

        // Load coinciding with the frame-start tick is shown in that frame.
        cyc(3);
        carga = 1'b1; valor = 16'h00F0;
        cyc(1);
        carga = 1'b0;
        chk_slot("byp.s0", 4'b0001, 4'h0, 2'd0, 1'b1);
        chk("byp.pendente", 16'(pendente), 16'd0);
        cyc(4);
        chk_slot("byp.s1", 4'b0010, 4'hF, 2'd1, 1'b0);
        chk("byp.s1.pendente", 16'(pendente), 16'd0);
        cyc(4);
        chk_slot("byp.s2", 4'b0100, 4'h0, 2'd2, 1'b0);

        // Disable with prescaler at 2; load while disabled.
        cyc(2);
        habilita = 1'b0; carga = 1'b1; valor = 16'h9876;
        cyc(1);
        carga = 1'b0;
        chk_slot("dis", 4'b0000, 4'h0, 2'd2, 1'b0);
        chk("dis.pendente", 16'(pendente), 16'd1);
        cyc(2);
        chk("dis+2.indice", 16'(indice), 16'd2);
        chk("dis+2.anodo", 16'(anodo), 16'd0);
        habilita = 1'b1;
        cyc(1);
        chk("en+1.anodo", 16'(anodo), 16'd0);
        cyc(1);
        chk_slot("en+2", 4'b1000, 4'h0, 2'd3, 1'b0);
        cyc(4);
        chk_slot("f5s0", 4'b0001, 4'h6, 2'd0, 1'b1);
        chk("f5s0.pendente", 16'(pendente), 16'd0);

        // Reset mid-frame discards a pending load.
        cyc(1);
        carga = 1'b1; valor = 16'h1111;
        cyc(1);
        carga = 1'b0;
        chk("pre_rst.pendente", 16'(pendente), 16'd1);
        rst_n = 1'b0;
        cyc(1);
        chk_slot("rst2", 4'b0000, 4'h0, 2'd3, 1'b0);
        chk("rst2.pendente", 16'(pendente), 16'd0);

        // Leading zeros: 0050 then 0.
        rst_n = 1'b1; carga = 1'b1; valor = 16'h0050;
        cyc(1);
        carga = 1'b0;
        cyc(3);
        chk_slot("z.s0", 4'b0001, 4'h0, 2'd0, 1'b1);
        cyc(4);
        chk_slot("z.s1", 4'b0010, 4'h5, 2'd1, 1'b0);
        cyc(4);
`ifdef VARREDURA_SUPRIME_ZEROS_EN
        chk_slot("z.s2", 4'b0000, 4'h0, 2'd2, 1'b0);
`else
        chk_slot("z.s2", 4'b0100, 4'h0, 2'd2, 1'b0);
`endif
        cyc(4);
`ifdef VARREDURA_SUPRIME_ZEROS_EN
        chk_slot("z.s3", 4'b0000, 4'h0, 2'd3, 1'b0);
`else
        chk_slot("z.s3", 4'b1000, 4'h0, 2'd3, 1'b0);
`endif
        carga = 1'b1; valor = 16'h0000;
        cyc(1);
        carga = 1'b0;
        cyc(3);
        chk_slot("z0.s0", 4'b0001, 4'h0, 2'd0, 1'b1);
        cyc(4);
`ifdef VARREDURA_SUPRIME_ZEROS_EN
        chk_slot("z0.s1", 4'b0000, 4'h0, 2'd1, 1'b0);
`else
        chk_slot("z0.s1", 4'b0010, 4'h0, 2'd1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
